// File: rtl/uart_echo_if.sv
// uart_echo_if: host-side UART data handshake pairs (DataIn towards the UART, DataOut from it).
interface uart_echo_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  modport master(output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid);
  modport slave(input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/uart_echo_tester.sv
// uart_echo_tester: sends NUM_WORDS pattern words, checks each echo against an in-flight FIFO.
module uart_echo_tester #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    NUM_WORDS      = 16,
  parameter int                    OUTSTANDING    = 1,
  parameter int                    TIMEOUT_CYCLES = 100000,
  parameter logic [DATA_WIDTH-1:0] SEED           = 8'h7a,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS      = 8'hB8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  uart_echo_if.master uart,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [15:0] first_err_idx_o
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  // power-of-two depth lets the pointers wrap naturally; inflight caps occupancy
  logic [DATA_WIDTH-1:0] mem_q [2**PW];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [15:0]           sent_q, recv_q, recv_d, err_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  tx_fire, rx_fire, pop, bad, finish, tmo_hit;
  assign uart.tx_data  = pat_q;
  assign uart.tx_valid = state_q == RUN && sent_q < 16'(NUM_WORDS) && inflight_q < CW'(OUTSTANDING);
  assign uart.rx_ready = state_q == RUN;
  assign busy_o        = state_q == RUN;
  assign done_o        = state_q == DONE;
  always_comb begin
    tx_fire    = uart.tx_valid && uart.tx_ready;
    rx_fire    = uart.rx_valid && uart.rx_ready;
    pop        = rx_fire && inflight_q != '0;
    bad        = rx_fire && (inflight_q == '0 || mem_q[rd_q] != uart.rx_data);
    inflight_d = inflight_q + CW'(tx_fire) - CW'(pop);
    recv_d     = recv_q + 16'(pop);
    err_d      = (bad && err_count_o != 16'hFFFF) ? err_count_o + 16'd1 : err_count_o;
    tmo_d      = rx_fire ? '0 : inflight_q != '0 ? tmo_q + TW'(1) : tmo_q;
    tmo_hit    = tmo_d == TW'(TIMEOUT_CYCLES);
    finish     = recv_d == 16'(NUM_WORDS) && inflight_d == '0;
    pat_d      = mode_q == 2'd1 ? pat_q + DATA_WIDTH'(1) :
                 mode_q == 2'd2 ? (pat_q << 1) ^ (pat_q[DATA_WIDTH-1] ? LFSR_TAPS : '0) : pat_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mode_q          <= '0;
      pat_q           <= SEED;
      mem_q           <= '{default: '0};
      wr_q            <= '0;
      rd_q            <= '0;
      inflight_q      <= '0;
      sent_q          <= '0;
      recv_q          <= '0;
      tmo_q           <= '0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      err_count_o     <= '0;
      first_err_idx_o <= 16'hFFFF;
    end else if (state_q != RUN) begin
      if (start_i) begin
        state_q         <= RUN;
        mode_q          <= mode_i;
        pat_q           <= (mode_i == 2'd2 && SEED == '0) ? DATA_WIDTH'(1) : SEED;
        wr_q            <= '0;
        rd_q            <= '0;
        inflight_q      <= '0;
        sent_q          <= '0;
        recv_q          <= '0;
        tmo_q           <= '0;
        pass_o          <= 1'b0;
        timeout_o       <= 1'b0;
        err_count_o     <= '0;
        first_err_idx_o <= 16'hFFFF;
      end
    end else begin
      if (tx_fire) begin
        mem_q[wr_q] <= pat_q;
        wr_q        <= wr_q + PW'(1);
        sent_q      <= sent_q + 16'd1;
        pat_q       <= pat_d;
      end
      if (pop) rd_q <= rd_q + PW'(1);
      inflight_q  <= inflight_d;
      recv_q      <= recv_d;
      tmo_q       <= tmo_d;
      err_count_o <= err_d;
      if (bad && first_err_idx_o == 16'hFFFF) first_err_idx_o <= recv_q;
      if (finish || tmo_hit) begin
        state_q   <= DONE;
        timeout_o <= !finish;
        pass_o    <= finish && err_d == '0;
        if (!finish) inflight_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_echo_tester.sv
// tb_uart_echo_tester: table-driven and randomized echo runs scored against a queue-based model.
module tb_uart_echo_tester;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic [1:0] mode_s = 0;
  logic busy, done, pass, tmo, busy2, done2, pass2, tmo2;
  logic [15:0] errc, fidx, errc2, fidx2;
  int checks = 0, errors = 0;
  uart_echo_if #(.DATA_WIDTH(8)) u();
  uart_echo_if #(.DATA_WIDTH(8)) u2();
  uart_echo_tester #(.DATA_WIDTH(8), .NUM_WORDS(16), .OUTSTANDING(4), .TIMEOUT_CYCLES(50),
                     .SEED(8'h7a), .LFSR_TAPS(8'hB8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode_s), .uart(u), .busy_o(busy),
    .done_o(done), .pass_o(pass), .timeout_o(tmo), .err_count_o(errc), .first_err_idx_o(fidx));
  uart_echo_tester #(.DATA_WIDTH(8), .NUM_WORDS(4), .OUTSTANDING(1), .TIMEOUT_CYCLES(50),
                     .SEED(8'hFE), .LFSR_TAPS(8'hB8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .mode_i(2'd1), .uart(u2), .busy_o(busy2),
    .done_o(done2), .pass_o(pass2), .timeout_o(tmo2), .err_count_o(errc2), .first_err_idx_o(fidx2));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model state
  logic [7:0] exp_q[$], eq_data[$];
  int eq_due[$];
  int m_err, m_recv, echo_idx, cyc = 0, delay = 1, rdy_mode = 0, inj = 0;
  logic [15:0] m_first, corrupt = 0;
  logic [7:0] m_pat;
  logic [1:0] m_mode;
  bit echo_on = 1, stall_prev = 0;
  logic [7:0] stall_data;

  function automatic logic [7:0] nxt(input logic [7:0] p, input logic [1:0] m);
    if (m == 2'd1) return p + 8'd1;
    if (m == 2'd2) return {p[6:0], 1'b0} ^ (p[7] ? 8'hB8 : 8'h00);
    return p;
  endfunction

  task automatic model_err();
    if (m_err < 65535) m_err++;
    if (m_first == 16'hFFFF) m_first = 16'(m_recv);
  endtask

  task automatic begin_model(input logic [1:0] m);
    exp_q.delete(); eq_data.delete(); eq_due.delete();
    m_err = 0; m_recv = 0; m_first = 16'hFFFF; echo_idx = 0; m_mode = m; m_pat = 8'h7a;
  endtask

  // echo path for the main DUT: observe at negedge, drive just after posedge
  initial begin
    logic [7:0] w;
    u.tx_ready = 0; u.rx_valid = 0; u.rx_data = 0;
    forever begin
      @(negedge clk);
      if (u.tx_valid && u.tx_ready) begin
        chk("tx_word", u.tx_data, m_pat);
        exp_q.push_back(u.tx_data);
        m_pat = nxt(m_pat, m_mode);
        if (echo_on) begin eq_data.push_back(u.tx_data); eq_due.push_back(cyc + delay); end
      end
      if (u.rx_valid && u.rx_ready) begin
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          if (w !== u.rx_data) model_err();
          m_recv++;
        end else model_err();
      end
      if (stall_prev) chk("tx_stable", u.tx_data, stall_data);
      stall_prev = u.tx_valid && !u.tx_ready;
      stall_data = u.tx_data;
      chk("inflight_le4", exp_q.size() <= 4, 1);
      @(posedge clk); #1;
      cyc++;
      u.tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !u.tx_ready :
                   rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inj > 0) begin
        u.rx_valid = 1; u.rx_data = 8'h55; inj--;
      end else if (eq_due.size() > 0 && eq_due[0] <= cyc) begin
        void'(eq_due.pop_front());
        u.rx_valid = 1;
        u.rx_data = eq_data.pop_front() ^ {7'd0, echo_idx < 16 && corrupt[echo_idx]};
        echo_idx++;
      end else u.rx_valid = 0;
    end
  end

  // one-cycle register loopback for the second DUT
  logic [7:0] seq2[$];
  initial begin
    logic f2;
    logic [7:0] d2;
    u2.tx_ready = 1; u2.rx_valid = 0; u2.rx_data = 0;
    forever begin
      @(negedge clk);
      f2 = u2.tx_valid && u2.tx_ready;
      d2 = u2.tx_data;
      if (f2) seq2.push_back(d2);
      @(posedge clk); #1;
      u2.rx_valid = f2; u2.rx_data = d2;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic go(input logic [1:0] m);
    begin_model(m); mode_s = m; start = 1; tick(); start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    chk({nm, " done"}, done, 1);
  endtask

  task automatic chk_res(input string nm, input logic [15:0] e, input logic [15:0] i, input logic p);
    chk({nm, " err_count"}, errc, e);
    chk({nm, " first_idx"}, fidx, i);
    chk({nm, " pass"}, pass, p);
    chk({nm, " timeout"}, tmo, 0);
    chk({nm, " busy"}, busy, 0);
  endtask

  typedef struct {
    logic [1:0] m; int dly; int rdy; logic [15:0] cor;
    logic [15:0] e_err; logic [15:0] e_idx; logic e_pass;
  } vec_t;
  vec_t vt [5];
  logic [7:0] exp2 [4];

  initial begin
    int n, fires;
    logic last;
    vt[0] = '{2'd1, 1,  0, 16'h0000, 16'd0, 16'hFFFF, 1'b1};
    vt[1] = '{2'd0, 1,  0, 16'h0044, 16'd2, 16'd2,    1'b0};
    vt[2] = '{2'd2, 10, 1, 16'h0000, 16'd0, 16'hFFFF, 1'b1};
    vt[3] = '{2'd1, 3,  2, 16'h8000, 16'd1, 16'd15,   1'b0};
    vt[4] = '{2'd3, 2,  0, 16'h0001, 16'd1, 16'd0,    1'b0};
    exp2 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    begin_model(0);
    repeat (3) tick();
    chk("rst busy", busy, 0); chk("rst done", done, 0); chk("rst pass", pass, 0);
    chk("rst timeout", tmo, 0); chk("rst err", errc, 0); chk("rst idx", fidx, 16'hFFFF);
    chk("rst tx_valid", u.tx_valid, 0); chk("rst rx_ready", u.rx_ready, 0);
    chk("rst tx_data", u.tx_data, 8'h7a);
    rst_n = 1; tick();

    // increment wrap through FE -> 01, done one cycle after the final echo
    start2 = 1; tick(); start2 = 0;
    n = 0; fires = 0;
    while (!done2 && n < 100) begin
      last = u2.rx_valid && u2.rx_ready;
      tick(); n++;
      if (last) begin
        fires++;
        if (fires == 4) chk("wrap done_after_last_rx", done2, 1);
      end
    end
    chk("wrap rx_fires", fires, 4);
    chk("wrap tx_count", seq2.size(), 4);
    for (int i = 0; i < 4; i++) if (seq2.size() > i) chk("wrap tx_seq", seq2[i], exp2[i]);
    chk("wrap pass", pass2, 1); chk("wrap err", errc2, 0); chk("wrap idx", fidx2, 16'hFFFF);

    for (int i = 0; i < 5; i++) begin
      delay = vt[i].dly; rdy_mode = vt[i].rdy; corrupt = vt[i].cor; echo_on = 1;
      go(vt[i].m);
      wait_done($sformatf("vec%0d", i));
      chk_res($sformatf("vec%0d", i), vt[i].e_err, vt[i].e_idx, vt[i].e_pass);
      chk($sformatf("vec%0d model_err", i), errc, m_err);
      chk($sformatf("vec%0d model_idx", i), fidx, m_first);
    end

    for (int i = 0; i < 6; i++) begin
      delay = $urandom_range(1, 12); rdy_mode = $urandom_range(0, 2);
      corrupt = 16'($urandom) & 16'($urandom) & 16'($urandom);
      go(2'($urandom_range(0, 3)));
      wait_done($sformatf("rnd%0d", i));
      chk_res($sformatf("rnd%0d", i), 16'(m_err), m_first, m_err == 0);
      chk($sformatf("rnd%0d model_recv", i), m_recv, 16);
    end

    // no echo: timeout 50 cycles after the first word, stray start ignored
    echo_on = 0; rdy_mode = 0;
    go(2'd0);
    n = 0;
    while (!done && n < 200) begin start = (n == 10); tick(); n++; end
    start = 0;
    chk("tmo cycles", n, 51);
    chk("tmo timeout", tmo, 1); chk("tmo pass", pass, 0); chk("tmo busy", busy, 0);
    chk("tmo err", errc, 0); chk("tmo idx", fidx, 16'hFFFF);

    // unsolicited echo before any send, then asynchronous reset mid-run
    rdy_mode = 3;
    go(2'd0);
    inj = 1;
    repeat (3) tick();
    chk("unsol err", errc, 1); chk("unsol idx", fidx, 0); chk("unsol busy", busy, 1);
    chk("unsol model", errc, m_err);
    #1 rst_n = 0;
    #1;
    chk("arst busy", busy, 0); chk("arst done", done, 0); chk("arst pass", pass, 0);
    chk("arst timeout", tmo, 0); chk("arst err", errc, 0); chk("arst idx", fidx, 16'hFFFF);
    chk("arst tx_valid", u.tx_valid, 0); chk("arst rx_ready", u.rx_ready, 0);
    chk("arst tx_data", u.tx_data, 8'h7a);
    tick(); rst_n = 1; tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_echo_tester.md
Name: uart_echo_tester

Overview:
- Synthesizable, self-checking echo-test engine. It replaces a hand-written single-byte echo bench with a parametrised traffic generator and checker.
- Drives the host side of the off-chip UART data interface: the DataIn/DataInValid/DataInReady and DataOut/DataOutValid/DataOutReady pairs.
- Sends NUM_WORDS words in a selectable pattern and checks that each echoed word equals the word sent. Supports up to OUTSTANDING words in flight.
- Reports pass/fail, error count, first failing index and timeout. Used in simulation and on-board to qualify the CPU echo program.

Parameters:
- DATA_WIDTH, 8, width of each UART word.
- NUM_WORDS, 16, words sent per run (1..65535).
- OUTSTANDING, 1, maximum words sent but not yet echoed (1..8). Sets the depth of the expected-value FIFO.
- TIMEOUT_CYCLES, 100000, idle cycles allowed while words are in flight.
- SEED, 8'h7a, first pattern value.
- LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (DATA_WIDTH bits).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE. Ignored while busy.
- mode  in  2  pattern: 0 fixed SEED, 1 increment, 2 LFSR, 3 reserved (behaves as 0). Sampled on start.
- tx_data  out  DATA_WIDTH  to UART DataIn.
- tx_valid  out  1  to UART DataInValid.
- tx_ready  in  1  from UART DataInReady.
- rx_data  in  DATA_WIDTH  from UART DataOut.
- rx_valid  in  1  from UART DataOutValid.
- rx_ready  out  1  to UART DataOutReady.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start.
- pass  out  1  valid when done: no errors and no timeout.
- timeout  out  1  run ended by timeout.
- err_count  out  16  mismatches plus unsolicited words; saturates at 16'hFFFF.
- first_err_idx  out  16  0-based receive index of the first error; 16'hFFFF if none.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - tx_valid=0, rx_ready=0, busy=0, done=0, pass=0, timeout=0.
  - err_count=0, first_err_idx=16'hFFFF, tx_data=SEED.
  - All counters and the expected-value FIFO cleared.
  - Asserting reset mid-run aborts the run immediately; no partial results are kept.
- States: IDLE -> RUN on start; RUN -> DONE on completion or timeout; DONE -> RUN on start.
- On an accepted start:
  - clear all counters and results; done=0, busy=1 from the next cycle;
  - pattern register loads SEED; in LFSR mode a SEED of 0 is replaced by 1.
- A tx fire is tx_valid && tx_ready. An rx fire is rx_valid && rx_ready.
- tx_valid:
  - Asserted in RUN while sent < NUM_WORDS and inflight < OUTSTANDING.
  - tx_data stays stable while tx_valid is high and not yet accepted.
  - On a tx fire: push tx_data into the expected FIFO, sent++, advance the pattern.
- Pattern advance by mode:
  - fixed: unchanged;
  - increment: +1 modulo 2^DATA_WIDTH (8'hFF -> 8'h00);
  - LFSR: next = (p<<1) ^ (p[MSB] ? LFSR_TAPS : 0), truncated to DATA_WIDTH.
- rx_ready is held at 1 throughout RUN and is 0 in IDLE and DONE.
- On an rx fire with inflight > 0:
  - pop the FIFO and compare against rx_data; recv++;
  - on mismatch, increment err_count (saturating) and set first_err_idx = recv index if it is still 16'hFFFF.
- On an rx fire with inflight == 0 (unsolicited word): count as an error with index = recv, recv unchanged, FIFO untouched.
- A tx fire and an rx fire in the same cycle leave inflight unchanged. A word pushed this cycle is never compared in the same cycle.
- Completion: recv == NUM_WORDS and inflight == 0 -> DONE next cycle, with done=1, busy=0, pass=(err_count==0).
- Timeout counter:
  - cleared on start and on every rx fire;
  - increments each RUN cycle with inflight > 0;
  - on reaching TIMEOUT_CYCLES -> DONE with timeout=1, pass=0; FIFO contents discarded.
- Latency: first tx_valid one cycle after start. done rises one cycle after the final rx fire.
- Result outputs hold their values in DONE until the next accepted start.

Test Plan:
- Loopback (rx = tx through a 1-cycle register, rx_valid = registered tx fire), mode 1, NUM_WORDS=16, OUTSTANDING=1 -> words 0x7A..0x89 sent; done, pass=1, err_count=0, first_err_idx=16'hFFFF.
- Loopback with rx_data bit 0 inverted on the 3rd and 7th echoes, mode 0 -> err_count=2, first_err_idx=2, pass=0.
- Increment mode, SEED=8'hFE, NUM_WORDS=4 -> tx sequence FE, FF, 00, 01; pass=1.
- OUTSTANDING=4 with an echo path delaying 10 cycles; tx_ready toggled every other cycle -> inflight never exceeds 4, tx_data stable while stalled, pass=1.
- No echo at all, TIMEOUT_CYCLES=50 -> first word sent, DONE reached 50 cycles later with timeout=1, pass=0, busy=0; extra start pulses while busy are ignored.
- Extra echo injected before any send, then rst_n pulsed low mid-run -> err_count=1 with first_err_idx=0 before reset; after reset all outputs return to their reset values within the same cycle.
